// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI-Lite slave memory with byte strobes, registered reads and SLVERR on out-of-range accesses
module axil_mem_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);
  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int WORD_W = ADDR_WIDTH - ADDR_LSB;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic                  aw_full, w_full;
  logic [WORD_W-1:0]     aw_word_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [WORD_W-1:0]     aw_word, ar_word;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  aw_oor, ar_oor;
  logic                  unused_ok;
  assign s_axil_awready = !aw_full && !reset;
  assign s_axil_wready  = !w_full && !reset;
  assign s_axil_arready = (!s_axil_rvalid || s_axil_rready) && !reset;
  assign aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_hs    = s_axil_wvalid && s_axil_wready;
  assign ar_hs   = s_axil_arvalid && s_axil_arready;
  assign aw_word = aw_full ? aw_word_q : s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_data = w_full ? w_data_q : s_axil_wdata;
  assign wr_strb = w_full ? w_strb_q : s_axil_wstrb;
  assign ar_word = s_axil_araddr[ADDR_WIDTH-1:ADDR_LSB];
  assign aw_oor  = (aw_word >> DEPTH_LOG2) != '0;
  assign ar_oor  = (ar_word >> DEPTH_LOG2) != '0;
  assign commit  = (aw_full || aw_hs) && (w_full || w_hs) && (!s_axil_bvalid || s_axil_bready) && !reset;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[ADDR_LSB-1:0], s_axil_araddr[ADDR_LSB-1:0]};
  // write channel: holding registers park an early AW or W until its partner arrives and B is free
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      aw_word_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= 2'b00;
    end else if (commit) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      s_axil_bvalid <= 1'b1;
      s_axil_bresp  <= aw_oor ? 2'b10 : 2'b00;
    end else begin
      if (aw_hs) begin
        aw_full   <= 1'b1;
        aw_word_q <= s_axil_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (s_axil_bready) s_axil_bvalid <= 1'b0;
    end
  end
  // memory array: byte-strobed write on an in-range commit, never reset
  always_ff @(posedge clk) begin
    if (commit && !aw_oor)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (wr_strb[i]) mem[aw_word[DEPTH_LOG2-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
  end
  // read channel: registered data, held while the master stalls R
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= ar_oor ? '0 : mem[ar_word[DEPTH_LOG2-1:0]];
      s_axil_rresp  <= ar_oor ? 2'b10 : 2'b00;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_mem_slave.sv
// tb_axil_mem_slave: scoreboard bench for axil_mem_slave with directed write/read vectors
module tb_axil_mem_slave;
  typedef struct {logic [1:0] resp; logic [31:0] data;} rexp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  int n_cmp = 0, n_err = 0, b_cnt = 0, r_cnt = 0, b0, r0;
  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  rexp_t       re;
  logic        stall_prev = 1'b0, tog;
  logic [31:0] hold_d;
  logic [1:0]  hold_r;

  axil_mem_slave dut (
    .clk(clk), .reset(reset),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pop the scoreboard on every B/R handshake and watch R stability during stalls
  always @(negedge clk) begin
    if (!reset && bvalid && bready) begin
      b_cnt++;
      if (b_q.size() == 0) chk("b_unexpected", 32'(bresp), 32'hffff_ffff);
      else chk("bresp", 32'(bresp), 32'(b_q.pop_front()));
    end
    if (!reset && rvalid && rready) begin
      r_cnt++;
      if (r_q.size() == 0) chk("r_unexpected", rdata, 32'hffff_ffff);
      else begin
        re = r_q.pop_front();
        chk("rresp", 32'(rresp), 32'(re.resp));
        chk("rdata", rdata, re.data);
      end
    end
    if (stall_prev && rvalid) begin
      chk("r_hold_data", rdata, hold_d);
      chk("r_hold_resp", 32'(rresp), 32'(hold_r));
    end
    stall_prev = rvalid && !rready;
    hold_d = rdata;
    hold_r = rresp;
  end

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
    bit ad = 0, wd = 0, ha, hw;
    int k = 0;
    b_q.push_back(er);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(ad && wd) && k < 100) begin
      @(negedge clk);
      ha = awvalid && awready;
      hw = wvalid && wready;
      @(posedge clk); #1;
      if (ha) begin awvalid = 1'b0; ad = 1; end
      if (hw) begin wvalid = 1'b0; wd = 1; end
      k++;
    end
    if (!(ad && wd)) begin
      chk("wr_timeout", 32'(a), 32'hffff_ffff);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] ed, input logic [1:0] er);
    bit h;
    int k = 0;
    rexp_t e;
    e.resp = er; e.data = ed;
    r_q.push_back(e);
    araddr = a; arvalid = 1'b1;
    h = 0;
    while (!h && k < 100) begin
      @(negedge clk);
      h = arvalid && arready;
      @(posedge clk); #1;
      k++;
    end
    arvalid = 1'b0;
    if (!h) chk("rd_timeout", 32'(a), 32'hffff_ffff);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", 32'(awready), 1);
    chk("post_rst_wready", 32'(wready), 1);
    chk("post_rst_arready", 32'(arready), 1);
    // simultaneous AW/W, then read back
    @(posedge clk); #1;
    wr(16'h0010, 32'hDEADBEEF, 4'hF, 2'b00);
    @(negedge clk); chk("b_latency", 32'(bvalid), 1);
    @(posedge clk); #1;
    rd(16'h0010, 32'hDEADBEEF, 2'b00);
    @(negedge clk); chk("r_latency", 32'(rvalid), 1);
    // AW three cycles ahead of W
    @(posedge clk); #1;
    b_q.push_back(2'b00);
    awaddr = 16'h0020; awvalid = 1'b1;
    @(negedge clk); chk("gap_aw_hs", 32'(awready), 1);
    @(posedge clk); #1 awvalid = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("gap_awready", 32'(awready), 0);
      @(posedge clk); #1;
    end
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); chk("gap_w_hs", 32'(wready), 1);
    @(posedge clk); #1 wvalid = 1'b0;
    @(negedge clk); chk("gap_bvalid", 32'(bvalid), 1);
    @(posedge clk); #1;
    wr(16'h0020, 32'hAABBCCDD, 4'h2, 2'b00);
    rd(16'h0020, 32'h1122CC44, 2'b00);
    // out-of-range write must not alias onto word 0
    wr(16'h0000, 32'hCAFEF00D, 4'hF, 2'b00);
    wr(16'h1000, 32'h12345678, 4'hF, 2'b10);
    rd(16'h0000, 32'hCAFEF00D, 2'b00);
    rd(16'h1000, 32'h0000_0000, 2'b10);
    // B backpressure with three writes offered
    repeat (2) @(posedge clk); #1;
    b0 = b_cnt;
    bready = 1'b0;
    wr(16'h0100, 32'hA1A1A1A1, 4'hF, 2'b00);
    wr(16'h0104, 32'hA2A2A2A2, 4'hF, 2'b00);
    fork
      wr(16'h0108, 32'hA3A3A3A3, 4'hF, 2'b00);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_bvalid", 32'(bvalid), 1);
          chk("bp_awready", 32'(awready), 0);
          chk("bp_wready", 32'(wready), 0);
        end
        @(posedge clk); #1 bready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("bp_b_count", 32'(b_cnt - b0), 3);
    rd(16'h0100, 32'hA1A1A1A1, 2'b00);
    rd(16'h0104, 32'hA2A2A2A2, 2'b00);
    rd(16'h0108, 32'hA3A3A3A3, 2'b00);
    // streaming reads with rready toggling
    for (int i = 0; i < 8; i++) wr(16'(4 * i), 32'h1000_0000 + 32'(i) * 32'h111, 4'hF, 2'b00);
    repeat (2) @(posedge clk); #1;
    r0 = r_cnt;
    tog = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) rd(16'(4 * i), 32'h1000_0000 + 32'(i) * 32'h111, 2'b00);
        tog = 1'b0;
      end
      begin
        while (tog) begin
          @(posedge clk); #1 rready = ~rready;
        end
        rready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("stream_r_count", 32'(r_cnt - r0), 8);
    // read-before-write on the same word in the same cycle
    wr(16'h0040, 32'h0000_0003, 4'hF, 2'b00);
    repeat (2) @(posedge clk); #1;
    fork
      wr(16'h0040, 32'h0000_0005, 4'hF, 2'b00);
      rd(16'h0040, 32'h0000_0003, 2'b00);
    join
    rd(16'h0040, 32'h0000_0005, 2'b00);
    // reset while an AW is parked
    repeat (2) @(posedge clk); #1;
    awaddr = 16'h0040; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk); chk("park_awready", 32'(awready), 0);
    @(posedge clk); #1;
    reset = 1'b1; wdata = 32'h0000_0099; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_wready", 32'(wready), 0);
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    @(posedge clk); #1 reset = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_awready", 32'(awready), 1);
    chk("mid_rst_bvalid2", 32'(bvalid), 0);
    @(posedge clk); #1;
    rd(16'h0040, 32'h0000_0005, 2'b00);
    repeat (5) @(posedge clk);
    chk("b_q_empty", 32'(b_q.size()), 0);
    chk("r_q_empty", 32'(r_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axil_mem_slave.md
# axil_mem_slave

Synthesizable AXI-Lite slave memory that consumes the five AXI-Lite channels driven by the switchboard AXI-Lite master model. It serves as the standard endpoint in switchboard AXI-Lite testbenches. Writes apply byte strobes, and reads return registered data. Out-of-range accesses complete with SLVERR. Read and write paths are independent, and each sustains one transaction per cycle.

## Interface
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- ADDR_WIDTH, 16, byte address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- DEPTH_LOG2, 10, log2 of the number of memory words; DEPTH_LOG2 + log2(STRB_WIDTH) <= ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  accepted, ignored.
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  accepted, ignored.
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake.

## Operation
- Address decode: ADDR_LSB = log2(STRB_WIDTH).
  - The low ADDR_LSB bits are ignored; unaligned addresses are truncated to the word.
  - Word index = addr[ADDR_LSB +: DEPTH_LOG2].
  - Out of range when addr[ADDR_WIDTH-1 : ADDR_LSB+DEPTH_LOG2] != 0.
- Write path:
  - Two one-entry holding registers, aw_full and w_full.
  - awready = !aw_full; wready = !w_full.
  - have_aw = aw_full | (awvalid & awready); have_w likewise.
  - commit = have_aw & have_w & (!bvalid | bready).
  - On commit:
    - In range: for each strobe bit i, byte i of mem[index] <= wdata byte i. bresp <= 2'b00 (OKAY).
    - Out of range: no memory write. bresp <= 2'b10 (SLVERR).
    - bvalid <= 1. Both holding registers end empty.
  - A handshake that does not commit in the same cycle loads its holding register.
  - bvalid clears on bready when no new commit occurs that cycle.
- Read path:
  - arready = !rvalid | rready.
  - On AR handshake:
    - In range: rdata <= mem[index], rresp <= OKAY.
    - Out of range: rdata <= 0, rresp <= SLVERR.
    - rvalid <= 1.
  - Otherwise rvalid clears on rready.
  - rdata and rresp are held stable while rvalid & !rready.
- Same-cycle read and write commit to the same word: the read returns the old data (read-before-write).
- Memory contents are not reset.

## Timing
- Reset values:
  - awready, wready, arready = 0 while reset is high.
  - bvalid, rvalid = 0; bresp, rresp = 0; rdata = 0.
  - aw_full, w_full = 0.
  - awready, wready and arready are 1 in the first cycle after reset deasserts.
- Write latency: bvalid rises the cycle after the later of the AW and W handshakes, provided B is free.
- Read latency: rvalid rises the cycle after the AR handshake.
- Throughput: with bready and rready held high, one write and one read are accepted every cycle.
- B backpressure: with bvalid high and bready low, a new AW/W pair fills the holding registers. awready and wready then drop until the pair commits, which happens in the cycle bready rises.
- R backpressure: with rvalid high and rready low, arready = 0.
- Reset asserted mid-transaction: holding registers are discarded and bvalid/rvalid drop the next cycle. No partial write occurs after the reset edge.
- Valid signals from the master may assert in any order. AW before W by N cycles is legal, and so is the reverse.

## Test plan
- Reset released; AW 0x0010 + W 0xDEADBEEF, strb 0xF in the same cycle; bready=1 -> bvalid next cycle, bresp=00. Then AR 0x0010 -> rvalid next cycle, rdata=0xDEADBEEF, rresp=00.
- AW 0x0020 issued, W 0x11223344 three cycles later -> awready=0 during the gap, bvalid the cycle after the W handshake. Then W strb 0x2 data 0xAABBCCDD to 0x0020 -> readback 0x1122CC44.
- DEPTH_LOG2=10, write to 0x1000 -> bresp=10, no memory change (readback of 0x0000 unchanged). Read from 0x1000 -> rresp=10, rdata=0.
- bready=0 for 5 cycles with 3 writes offered -> exactly 1 B pending, second pair held, awready=wready=0. After bready=1, the B responses arrive in order and memory holds all 3 values.
- Back-to-back reads of 0x0..0x1C with rready toggling 1/0 -> every word returned in order, no drops or duplicates, and rdata stable during stalls.
- Write 0x5 to 0x0040 and read 0x0040 committing in the same cycle (old value 0x3) -> rdata=0x3; a later read returns 0x5. Reset asserted while AW is held -> no write occurs and bvalid=0.
